// File: rtl/seg7_scan_scheduler.sv
// Four-digit seven-segment scan scheduler: digit slots with guard gap,
// per-frame score/message select and optional game-over blink.
module seg7_scan_scheduler #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] SCORE_IN,
    input  logic [15:0] MSG_IN,
    input  logic        GAME_OVER,
    input  logic        BLINK_EN,
    output logic [3:0]  IN1_NIBBLE,
    output logic [3:0]  IN2_NIBBLE,
    output logic [1:0]  MUX_SEL,
    output logic [3:0]  ANODE,
    output logic [1:0]  DIGIT_IDX,
    output logic        FRAME_TICK
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
    localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic {GUARD, ON} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [1:0]    digit_nx;
    logic [1:0]    sel_nx;
    logic          slot_end, frame_end;
    logic          phase, phase_nx;
    logic [FW-1:0] frames, frames_nx;
    logic [3:0]    anode_nx;
    logic [3:0]    nib_base;

    // Next-state view; outputs are registered from it so they line up with count.
    always_comb begin
        slot_end  = (count == LAST);
        frame_end = slot_end && (DIGIT_IDX == 2'd3);
        count_nx  = slot_end ? '0 : count + 1'b1;
        digit_nx  = slot_end ? DIGIT_IDX + 2'd1 : DIGIT_IDX;
        nib_base  = {digit_nx, 2'b00};
        state_nx  = state;
        unique case (state)
            GUARD: if (!slot_end && count_nx >= GUARD_END) state_nx = ON;
            ON:    if (slot_end) state_nx = GUARD;
        endcase
        sel_nx    = frame_end ? {1'b0, GAME_OVER} : MUX_SEL;
        phase_nx  = phase;
        frames_nx = frames;
        if (frame_end) begin
            if (sel_nx == 2'b01 && BLINK_EN) begin
                if (frames == FLAST) begin
                    frames_nx = '0;
                    phase_nx  = ~phase;
                end else begin
                    frames_nx = frames + 1'b1;
                end
            end else begin
                frames_nx = '0;
                phase_nx  = 1'b0;
            end
        end
        if (state_nx == GUARD || phase_nx)
            anode_nx = 4'b1111;
        else
            anode_nx = ~(4'b0001 << digit_nx);
    end

    // Scan FSM, prescaler, blink state and all registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= GUARD;
            count      <= '0;
            DIGIT_IDX  <= 2'd0;
            IN1_NIBBLE <= 4'd0;
            IN2_NIBBLE <= 4'd0;
            MUX_SEL    <= 2'b00;
            ANODE      <= 4'b1111;
            FRAME_TICK <= 1'b0;
            phase      <= 1'b0;
            frames     <= '0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            DIGIT_IDX  <= digit_nx;
            MUX_SEL    <= sel_nx;
            ANODE      <= anode_nx;
            FRAME_TICK <= (count_nx == LAST) && (digit_nx == 2'd3);
            phase      <= phase_nx;
            frames     <= frames_nx;
            if (slot_end) begin
                IN1_NIBBLE <= SCORE_IN[nib_base +: 4];
                IN2_NIBBLE <= MSG_IN[nib_base +: 4];
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Directed bench for seg7_scan_scheduler with REFRESH_DIV=4,
// GUARD_CYCLES=1, BLINK_FRAMES=2.
module tb_seg7_scan_scheduler;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] SCORE_IN = 16'h0;
    logic [15:0] MSG_IN = 16'h0;
    logic        GAME_OVER = 1'b0;
    logic        BLINK_EN = 1'b0;
    logic [3:0]  IN1_NIBBLE, IN2_NIBBLE, ANODE;
    logic [1:0]  MUX_SEL, DIGIT_IDX;
    logic        FRAME_TICK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seg7_scan_scheduler #(
        .REFRESH_DIV(4), .GUARD_CYCLES(1), .BLINK_FRAMES(2)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .SCORE_IN(SCORE_IN), .MSG_IN(MSG_IN),
        .GAME_OVER(GAME_OVER), .BLINK_EN(BLINK_EN),
        .IN1_NIBBLE(IN1_NIBBLE), .IN2_NIBBLE(IN2_NIBBLE),
        .MUX_SEL(MUX_SEL), .ANODE(ANODE),
        .DIGIT_IDX(DIGIT_IDX), .FRAME_TICK(FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] score;
        logic        go;
        logic [3:0]  an;
        logic [3:0]  n1;
        logic [3:0]  n2;
        logic [1:0]  sel;
        logic [1:0]  idx;
        logic        tick;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    function automatic logic [16:0] outs();
        return {ANODE, IN1_NIBBLE, IN2_NIBBLE, MUX_SEL, DIGIT_IDX, FRAME_TICK};
    endfunction

    initial begin
        tbl[0]  = '{16'h4321, 1'b0, 4'hF, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0};
        tbl[1]  = '{16'h4321, 1'b0, 4'hE, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0};
        tbl[2]  = '{16'h4321, 1'b0, 4'hE, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0};
        tbl[3]  = '{16'h4321, 1'b0, 4'hE, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0};
        tbl[4]  = '{16'h4321, 1'b0, 4'hF, 4'h2, 4'hB, 2'b00, 2'd1, 1'b0};
        tbl[5]  = '{16'h4321, 1'b0, 4'hD, 4'h2, 4'hB, 2'b00, 2'd1, 1'b0};
        tbl[6]  = '{16'h4321, 1'b0, 4'hD, 4'h2, 4'hB, 2'b00, 2'd1, 1'b0};
        tbl[7]  = '{16'h4321, 1'b0, 4'hD, 4'h2, 4'hB, 2'b00, 2'd1, 1'b0};
        tbl[8]  = '{16'h4321, 1'b0, 4'hF, 4'h3, 4'hC, 2'b00, 2'd2, 1'b0};
        tbl[9]  = '{16'h4321, 1'b0, 4'hB, 4'h3, 4'hC, 2'b00, 2'd2, 1'b0};
        tbl[10] = '{16'h4321, 1'b0, 4'hB, 4'h3, 4'hC, 2'b00, 2'd2, 1'b0};
        tbl[11] = '{16'h4321, 1'b0, 4'hB, 4'h3, 4'hC, 2'b00, 2'd2, 1'b0};
        tbl[12] = '{16'h4321, 1'b0, 4'hF, 4'h4, 4'hD, 2'b00, 2'd3, 1'b0};
        tbl[13] = '{16'h4321, 1'b0, 4'h7, 4'h4, 4'hD, 2'b00, 2'd3, 1'b0};
        tbl[14] = '{16'h4321, 1'b0, 4'h7, 4'h4, 4'hD, 2'b00, 2'd3, 1'b0};
        tbl[15] = '{16'h4321, 1'b0, 4'h7, 4'h4, 4'hD, 2'b00, 2'd3, 1'b1};
        tbl[16] = '{16'h4321, 1'b0, 4'hF, 4'h1, 4'hA, 2'b00, 2'd0, 1'b0};
        tbl[17] = '{16'h4321, 1'b0, 4'hE, 4'h1, 4'hA, 2'b00, 2'd0, 1'b0};
        tbl[18] = '{16'h4321, 1'b0, 4'hE, 4'h1, 4'hA, 2'b00, 2'd0, 1'b0};
        tbl[19] = '{16'h4321, 1'b0, 4'hE, 4'h1, 4'hA, 2'b00, 2'd0, 1'b0};

        // Reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            SCORE_IN  = 16'($urandom);
            MSG_IN    = 16'($urandom);
            GAME_OVER = i[0];
            BLINK_EN  = i[1];
            @(negedge CLK);
            chk("reset_hold", 32'(outs()), 32'({4'hF, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0}));
        end

        MSG_IN    = 16'hDCBA;
        GAME_OVER = 1'b0;
        BLINK_EN  = 1'b0;
        SCORE_IN  = tbl[0].score;
        RESET_N   = 1'b1;
        cyc = 0;

        // Steady score scan.
        for (int i = 0; i < 20; i++) begin
            SCORE_IN  = tbl[i].score;
            GAME_OVER = tbl[i].go;
            chk($sformatf("scan_vec%0d", i), 32'(outs()),
                32'({tbl[i].an, tbl[i].n1, tbl[i].n2, tbl[i].sel, tbl[i].idx, tbl[i].tick}));
            step();
        end

        // GAME_OVER rises mid digit-1 slot.
        goto(21);
        GAME_OVER = 1'b1;
        goto(26);
        chk("go_mid_frame_sel", 32'(MUX_SEL), 32'(2'b00));
        goto(31);
        chk("go_frame_end_sel", 32'(MUX_SEL), 32'(2'b00));
        chk("go_frame_end_tick", 32'(FRAME_TICK), 32'(1'b1));
        goto(32);
        chk("go_new_frame", 32'(outs()), 32'({4'hF, 4'h1, 4'hA, 2'b01, 2'd0, 1'b0}));
        goto(33);
        chk("go_digit0_on", 32'(ANODE), 32'(4'hE));

        // Blink: 1 scan frame, then 2 blank / 2 scan.
        BLINK_EN = 1'b1;
        goto(49);
        chk("blink_scan_a", 32'(ANODE), 32'(4'hE));
        goto(65);
        chk("blink_blank_a", 32'(ANODE), 32'(4'hF));
        goto(69);
        chk("blink_blank_nib", 32'({ANODE, IN1_NIBBLE}), 32'({4'hF, 4'h2}));
        goto(81);
        chk("blink_blank_b", 32'(ANODE), 32'(4'hF));
        goto(94);
        chk("blink_blank_d3", 32'(ANODE), 32'(4'hF));
        goto(97);
        chk("blink_scan_b", 32'(ANODE), 32'(4'hE));
        goto(129);
        chk("blink_blank_c", 32'(ANODE), 32'(4'hF));
        BLINK_EN = 1'b0;
        goto(130);
        chk("blink_drop_hold", 32'(ANODE), 32'(4'hF));
        goto(145);
        chk("blink_drop_scan", 32'(ANODE), 32'(4'hE));

        // Score change mid-slot.
        goto(146);
        SCORE_IN = 16'h8765;
        goto(147);
        chk("score_mid_slot", 32'(IN1_NIBBLE), 32'(4'h1));
        goto(148);
        chk("score_next_slot", 32'({IN1_NIBBLE, DIGIT_IDX}), 32'({4'h6, 2'd1}));

        // Async reset pulse mid digit-2 slot.
        goto(154);
        chk("pre_reset_idx", 32'(DIGIT_IDX), 32'(2'd2));
        #1 RESET_N = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'({4'hF, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0}));
        @(negedge CLK);
        RESET_N = 1'b1;
        cyc = 0;
        chk("restart_guard", 32'(outs()), 32'({4'hF, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0}));
        step();
        chk("restart_on", 32'(outs()), 32'({4'hE, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0}));
        goto(16);
        chk("restart_frame", 32'({MUX_SEL, IN1_NIBBLE}), 32'({2'b01, 4'h5}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
